// File: rtl/hsi_s_rx_frm_ctrl.sv
// HSI slave receive frame controller: assembles one message into a single-frame buffer and
// hands committed frames to the consumer. Define HSI_RX_KEEP_BAD_FRAMES_EN to deliver bad frames.
module hsi_s_rx_frm_ctrl #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [7:0]        d,
  input  logic              d_rdy,
  input  logic              msg_end,
  input  logic [5:0]        rx_errs,
  input  logic              rd,
  input  logic              frm_ack,
  output logic [7:0]        q,
  output logic              q_vld,
  output logic              frm_rdy,
  output logic [ADDR_W:0]   frm_len,
  output logic [5:0]        frm_errs,
  output logic              frm_ovf,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned     Depth    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(Depth);

`ifdef HSI_RX_KEEP_BAD_FRAMES_EN
  localparam bit KeepBad = 1'b1;
`else
  localparam bit KeepBad = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StRecv, StReady, StSkip} state_e;

  state_e            state;
  logic [7:0]        mem [Depth];
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W:0]   rd_ptr;
  logic              overflow;
  logic              busy_in;

  logic              full;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   cnt_nxt;
  logic              ovf_nxt;
  logic              commit;
  logic              bad;
  logic              busy_nxt;
  logic              rd_ok;
  logic              drop_inc;

  always_comb begin
    full     = (state == StRecv) && (wr_cnt == DepthCnt);
    wr_en    = ((state == StIdle) || (state == StRecv)) && d_rdy && !full;
    wr_addr  = (state == StIdle) ? '0 : wr_cnt[ADDR_W-1:0];
    cnt_nxt  = ((state == StIdle) ? '0 : wr_cnt) + {{ADDR_W{1'b0}}, wr_en};
    ovf_nxt  = (state == StRecv) && (overflow || (d_rdy && full));
    // An empty message in IDLE is not a frame; a byte arriving with msg_end is.
    commit   = msg_end && ((state == StRecv) || ((state == StIdle) && d_rdy));
    bad      = (rx_errs != 6'd0) || ovf_nxt;
    busy_nxt = msg_end ? 1'b0 : (busy_in || d_rdy);
    rd_ok    = (state == StReady) && rd && !frm_ack && (rd_ptr < frm_len);
    drop_inc = (commit && bad && !KeepBad) ||
               (((state == StReady) || (state == StSkip)) && msg_end);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= StIdle;
      wr_cnt   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      busy_in  <= 1'b0;
      q        <= 8'h00;
      q_vld    <= 1'b0;
      frm_rdy  <= 1'b0;
      frm_len  <= '0;
      frm_errs <= 6'd0;
      frm_ovf  <= 1'b0;
      drop_cnt <= 8'h00;
    end else begin
      q_vld <= 1'b0;
      if (drop_inc && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      unique case (state)
        StIdle, StRecv: begin
          if (commit) begin
            frm_len  <= cnt_nxt;
            frm_errs <= rx_errs;
            frm_ovf  <= ovf_nxt;
            if (bad && !KeepBad) begin
              state    <= StIdle;
              wr_cnt   <= '0;
              overflow <= 1'b0;
            end else begin
              state    <= StReady;
              frm_rdy  <= 1'b1;
              wr_cnt   <= cnt_nxt;
              overflow <= ovf_nxt;
              rd_ptr   <= '0;
              busy_in  <= 1'b0;
            end
          end else if (state == StIdle) begin
            if (d_rdy) begin
              state  <= StRecv;
              wr_cnt <= cnt_nxt;
            end
          end else begin
            wr_cnt   <= cnt_nxt;
            overflow <= ovf_nxt;
          end
        end
        StReady: begin
          if (frm_ack) begin
            frm_rdy  <= 1'b0;
            rd_ptr   <= '0;
            wr_cnt   <= '0;
            overflow <= 1'b0;
            frm_ovf  <= 1'b0;
            busy_in  <= 1'b0;
            state    <= busy_nxt ? StSkip : StIdle;
          end else begin
            busy_in <= busy_nxt;
            if (rd_ok) begin
              q      <= mem[rd_ptr[ADDR_W-1:0]];
              q_vld  <= 1'b1;
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        StSkip: begin
          if (msg_end) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
